// File: rtl/sm4_tau_sched.sv
// Time-shares one external SM4 S-box between the round-function and key-expansion
// datapaths: each accepted 32-bit word is substituted byte by byte and returned whole.
module sm4_tau_sched #(
   parameter int SBOX_LAT  = 0,
   parameter bit LAST_INIT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [0:31] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [0:31] req1_data,
   output logic        req1_ready,
   output logic [0:7]  sbox_in,
   input  logic [0:7]  sbox_out,
   output logic        resp_valid,
   output logic        resp_id,
   output logic [0:31] resp_data,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t      state;
   logic [1:0]  cnt;
   logic [0:31] word_q;
   logic [0:31] result_q;
   logic [0:31] result_d;
   logic        id_q;
   logic        last_q;
   logic        in_idle;
   logic        grant0;
   logic        grant1;
   logic        wr_en;
   logic [1:0]  wr_idx;

   // Grants are gated by rst_n so ready reads 0 while reset is held.
   always_comb begin
      in_idle = rst_n && (state == IDLE);
      grant0  = in_idle && req0_valid && (!req1_valid || last_q);
      grant1  = in_idle && req1_valid && (!req0_valid || !last_q);
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign resp_valid = (state == DONE);
   assign busy       = (state != IDLE);

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      sbox_in = 8'h00;
      wr_en   = 1'b0;
      wr_idx  = cnt;
      if (state == ISSUE) begin
         sbox_in = word_q[{cnt, 3'b000} +: 8];
      end else if (state == DRAIN) begin
         sbox_in = word_q[24 +: 8];
      end
      if (SBOX_LAT == 0) begin
         wr_en  = (state == ISSUE);
         wr_idx = cnt;
      end else begin
         // A registered S-box returns the byte issued one cycle earlier.
         if (state == ISSUE) begin
            wr_en  = (cnt != 2'd0);
            wr_idx = cnt - 2'd1;
         end else if (state == DRAIN) begin
            wr_en  = 1'b1;
            wr_idx = 2'd3;
         end
      end
      result_d = result_q;
      if (wr_en) begin
         result_d[{wr_idx, 3'b000} +: 8] = sbox_out;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         word_q    <= 32'h0;
         result_q  <= 32'h0;
         id_q      <= 1'b0;
         last_q    <= LAST_INIT;
         resp_id   <= 1'b0;
         resp_data <= 32'h0;
      end else begin
         result_q <= result_d;
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  word_q <= grant1 ? req1_data : req0_data;
                  id_q   <= grant1;
                  last_q <= grant1;
                  cnt    <= 2'd0;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  if (SBOX_LAT == 0) begin
                     state     <= DONE;
                     resp_data <= result_d;
                     resp_id   <= id_q;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               state     <= DONE;
               resp_data <= result_d;
               resp_id   <= id_q;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sm4_tau_sched.sv
// Directed bench for sm4_tau_sched: one instance with a combinational S-box (a_*)
// and one with a registered S-box (b_*), both sharing clock and reset.
module tb_sm4_tau_sched;

   localparam logic [7:0] SBOX [0:255] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   logic        clk = 1'b0;
   logic        rst_n;

   logic        a_r0v, a_r1v, a_r0r, a_r1r, a_resp_valid, a_resp_id, a_busy;
   logic [0:31] a_r0d, a_r1d, a_resp_data;
   logic [0:7]  a_sbox_in, a_sbox_out;

   logic        b_r0v, b_r1v, b_r0r, b_r1r, b_resp_valid, b_resp_id, b_busy;
   logic [0:31] b_r0d, b_r1d, b_resp_data;
   logic [0:7]  b_sbox_in;
   logic [0:7]  b_sbox_out = 8'h00;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign a_sbox_out = SBOX[a_sbox_in];
   always @(posedge clk) b_sbox_out <= SBOX[b_sbox_in];

   sm4_tau_sched #(.SBOX_LAT(0), .LAST_INIT(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(a_r0v), .req0_data(a_r0d), .req0_ready(a_r0r),
      .req1_valid(a_r1v), .req1_data(a_r1d), .req1_ready(a_r1r),
      .sbox_in(a_sbox_in), .sbox_out(a_sbox_out),
      .resp_valid(a_resp_valid), .resp_id(a_resp_id), .resp_data(a_resp_data),
      .busy(a_busy)
   );

   sm4_tau_sched #(.SBOX_LAT(1), .LAST_INIT(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(b_r0v), .req0_data(b_r0d), .req0_ready(b_r0r),
      .req1_valid(b_r1v), .req1_data(b_r1d), .req1_ready(b_r1r),
      .sbox_in(b_sbox_in), .sbox_out(b_sbox_out),
      .resp_valid(b_resp_valid), .resp_id(b_resp_id), .resp_data(b_resp_data),
      .busy(b_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Each tick lands 1 time unit after a falling edge: mid-cycle, away from the active edge.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      int n_rv;
      int n_rdy;

      rst_n = 1'b0;
      a_r0v = 1'b1; a_r0d = 32'h0; a_r1v = 1'b0; a_r1d = 32'h0;
      b_r0v = 1'b0; b_r0d = 32'h0; b_r1v = 1'b0; b_r1d = 32'h0;

      // Reset state: a valid held during reset must not see ready.
      tick();
      check("rst_ready0", 32'(a_r0r), 0);
      check("rst_busy", 32'(a_busy), 0);
      check("rst_resp_valid", 32'(a_resp_valid), 0);
      check("rst_resp_id", 32'(a_resp_id), 0);
      check("rst_resp_data", 32'(a_resp_data), 32'h0);
      check("rst_sbox_in", 32'(a_sbox_in), 0);
      a_r0v = 1'b0;
      tick();
      rst_n = 1'b1;

      // Single request on the combinational S-box instance.
      tick();
      a_r0v = 1'b1; a_r0d = 32'h00010203;
      #1;
      check("t1_ready0", 32'(a_r0r), 1);
      check("t1_ready1", 32'(a_r1r), 0);
      check("t1_busy_c0", 32'(a_busy), 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k == 0) a_r0v = 1'b0;
         check("t1_sbox_in", 32'(a_sbox_in), k);
         check("t1_busy", 32'(a_busy), 1);
         check("t1_no_resp", 32'(a_resp_valid), 0);
      end
      tick();
      check("t1_resp_valid", 32'(a_resp_valid), 1);
      check("t1_resp_id", 32'(a_resp_id), 0);
      check("t1_resp_data", 32'(a_resp_data), 32'hd690e9fe);
      check("t1_busy_c5", 32'(a_busy), 1);
      tick();
      check("t1_resp_pulse", 32'(a_resp_valid), 0);
      check("t1_busy_c6", 32'(a_busy), 0);
      check("t1_resp_hold", 32'(a_resp_data), 32'hd690e9fe);

      // Edge bytes on the registered S-box instance.
      tick();
      b_r1v = 1'b1; b_r1d = 32'hff10ab7f;
      #1;
      check("t2_ready1", 32'(b_r1r), 1);
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 1) begin
            b_r1v = 1'b0;
            check("t2_sbox_first", 32'(b_sbox_in), 32'hff);
         end
         if (c == 5) check("t2_sbox_drain", 32'(b_sbox_in), 32'h7f);
         check("t2_no_resp", 32'(b_resp_valid), 0);
         check("t2_busy", 32'(b_busy), 1);
      end
      tick();
      check("t2_resp_valid", 32'(b_resp_valid), 1);
      check("t2_resp_id", 32'(b_resp_id), 1);
      check("t2_resp_data", 32'(b_resp_data), 32'h482bab9e);

      // Contention from reset: grants alternate starting with req0.
      tick();
      rst_n = 1'b0;
      a_r0v = 1'b1; a_r0d = 32'h00000000;
      a_r1v = 1'b1; a_r1d = 32'h01010101;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c <= 18; c++) begin
         if (c > 0) tick(); else #1;
         if (c % 6 == 0) begin
            check("t3_grant0", 32'(a_r0r), ((c / 6) % 2 == 0) ? 1 : 0);
            check("t3_grant1", 32'(a_r1r), ((c / 6) % 2 == 1) ? 1 : 0);
         end else begin
            check("t3_ready_busy", 32'({a_r0r, a_r1r}), 0);
         end
         if (c % 6 == 5) begin
            check("t3_resp_valid", 32'(a_resp_valid), 1);
            check("t3_resp_id", 32'(a_resp_id), ((c / 6) % 2 == 1) ? 1 : 0);
            check("t3_resp_data", 32'(a_resp_data), ((c / 6) % 2 == 1) ? 32'h90909090 : 32'hd6d6d6d6);
         end else begin
            check("t3_no_resp", 32'(a_resp_valid), 0);
         end
      end
      a_r0v = 1'b0; a_r1v = 1'b0;
      tick();

      // Request arriving while busy waits for the next IDLE cycle.
      tick();
      a_r0v = 1'b1; a_r0d = 32'h00010203;
      #1;
      check("t4_ready0", 32'(a_r0r), 1);
      for (int c = 1; c <= 11; c++) begin
         tick();
         if (c == 1) a_r0v = 1'b0;
         if (c == 2) begin a_r1v = 1'b1; a_r1d = 32'hff10ab7f; #1; end
         if (c == 7) a_r1v = 1'b0;
         if (c >= 2 && c <= 5) check("t4_ready1_low", 32'(a_r1r), 0);
         if (c == 5) begin
            check("t4_resp0_valid", 32'(a_resp_valid), 1);
            check("t4_resp0_id", 32'(a_resp_id), 0);
            check("t4_resp0_data", 32'(a_resp_data), 32'hd690e9fe);
         end
         if (c == 6) check("t4_ready1_idle", 32'(a_r1r), 1);
         if (c == 10) check("t4_no_early_resp", 32'(a_resp_valid), 0);
         if (c == 11) begin
            check("t4_resp1_valid", 32'(a_resp_valid), 1);
            check("t4_resp1_id", 32'(a_resp_id), 1);
            check("t4_resp1_data", 32'(a_resp_data), 32'h482bab9e);
         end
      end

      // Asynchronous reset in the middle of ISSUE.
      tick();
      a_r0v = 1'b1; a_r0d = 32'h00010203;
      #1;
      check("t5_ready0", 32'(a_r0r), 1);
      tick();
      a_r0v = 1'b0;
      tick();
      tick();
      check("t5_sbox_cnt2", 32'(a_sbox_in), 32'h02);
      rst_n = 1'b0;
      #1;
      check("t5_rst_sbox", 32'(a_sbox_in), 0);
      check("t5_rst_busy", 32'(a_busy), 0);
      check("t5_rst_resp_valid", 32'(a_resp_valid), 0);
      check("t5_rst_resp_id", 32'(a_resp_id), 0);
      check("t5_rst_resp_data", 32'(a_resp_data), 32'h0);
      tick();
      rst_n = 1'b1;
      n_rv = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (a_resp_valid) n_rv++;
      end
      check("t5_no_stale_resp", n_rv, 0);
      a_r0v = 1'b1; a_r0d = 32'h00010203;
      a_r1v = 1'b1; a_r1d = 32'h01010101;
      #1;
      check("t5_last_init_r0", 32'(a_r0r), 1);
      check("t5_last_init_r1", 32'(a_r1r), 0);
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 1) begin a_r0v = 1'b0; a_r1v = 1'b0; end
      end
      check("t5_resp_valid", 32'(a_resp_valid), 1);
      check("t5_resp_id", 32'(a_resp_id), 0);
      check("t5_resp_data", 32'(a_resp_data), 32'hd690e9fe);

      // A one-cycle req1 pulse during busy is never accepted.
      tick();
      tick();
      a_r0v = 1'b1; a_r0d = 32'h00000000;
      #1;
      check("t6_ready0", 32'(a_r0r), 1);
      n_rv = 0;
      n_rdy = 0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 1) a_r0v = 1'b0;
         if (c == 2) begin a_r1v = 1'b1; a_r1d = 32'h01010101; #1; end
         if (c == 3) begin a_r1v = 1'b0; #1; end
         if (a_r1r) n_rdy++;
         if (a_resp_valid) n_rv++;
         if (c == 5) check("t6_resp_data", 32'(a_resp_data), 32'hd6d6d6d6);
      end
      check("t6_ready1_never", n_rdy, 0);
      check("t6_one_resp", n_rv, 1);
      check("t6_idle_end", 32'(a_busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
